mod4051_accumulator: RTL and testbench
======================================

MOD4051_ACCUMULATOR -- requirements
Module: mod4051_accumulator

Interface
REQ-001 SHALL have parameter MOD, default 4051, modulus applied to every sum.
REQ-002 SHALL have parameter W, default 12, width of residue data; MOD < 2^W and 2^W < 2*MOD.
REQ-003 SHALL have parameter CW, default 10, width of the term counter.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  upstream term (LUT-stage residue z11..z00) present.
REQ-007 in_ready  output  1  block accepts a term this cycle.
REQ-008 in_data  input  W  partial residue from the upstream 6-input residue LUT stage.
REQ-009 in_last  input  1  term is the final term of the current frame.
REQ-010 out_valid  output  1  frame result available.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 out_data  output  W  frame sum modulo MOD, always < MOD.
REQ-013 out_count  output  CW  number of terms accepted in the frame, saturating at 2^CW-1.
REQ-014 out_err  output  1  at least one term in the frame had in_data >= MOD.

Function
REQ-015 A term SHALL be accepted exactly when in_valid and in_ready are both high on a rising edge.
REQ-016 FSM SHALL have states IDLE (acc=0, no term yet), ACC (frame open), HOLD (result presented).
REQ-017 in_ready SHALL be 1 in IDLE and ACC and 0 in HOLD.
REQ-018 On an accepted term, t = in_data - MOD if in_data >= MOD, else in_data; t < MOD.
REQ-019 Next acc SHALL be s - MOD if s >= MOD, else s, where s = acc + t computed W+1 bits wide.
REQ-020 Accepted term with in_last=0: IDLE->ACC or ACC->ACC; acc, count, err updated.
REQ-021 Accepted term with in_last=1 (from IDLE or ACC): ->HOLD; the reduced final sum, count and err SHALL be loaded into out_data/out_count/out_err, and out_valid SHALL be 1 in the next cycle (latency 1 clock from last beat).
REQ-022 A single-term frame (in_last=1 accepted in IDLE) SHALL produce out_data = reduced t, out_count = 1.
REQ-023 In HOLD, out_data, out_count, out_err SHALL remain stable while out_valid=1 and out_ready=0.
REQ-024 In HOLD with out_ready=1: ->IDLE next cycle, out_valid=0, acc=0, count=0, err=0; in_ready=1 in that IDLE cycle (no same-cycle pass-through; one bubble per frame).
REQ-025 out_ready SHALL be ignored outside HOLD; in_valid SHALL be ignored in HOLD.
REQ-026 Term counter SHALL increment per accepted term and saturate at 2^CW-1 without wrapping.
REQ-027 out_err SHALL be sticky within a frame: set if any accepted term had in_data >= MOD; cleared on result hand-off.
REQ-028 in_ready and out_valid SHALL be driven only from registered state (no combinational path from in_valid or out_ready).
REQ-029 in_data and in_last SHALL be don't-care when in_valid=0.

Reset
REQ-030 rst_n low SHALL immediately force state IDLE, acc=0, count=0, err=0, out_valid=0, out_data=0, out_count=0, out_err=0, in_ready=1 (after release).
REQ-031 Reset asserted mid-frame or in HOLD SHALL discard the partial sum/result; first frame after release starts from acc=0.
REQ-032 Release of rst_n SHALL be treated as asynchronous assertion / synchronous-effect deassertion; no term accepted on the release edge is lost or duplicated.

Verification
REQ-033 Frame {4050, 1 last}, out_ready=1 -> out_valid one cycle after last beat, out_data=0, out_count=2, out_err=0.
REQ-034 Frame {2000, 2000, 100 last} -> out_data=49, out_count=3, out_err=0.
REQ-035 Frame {4095 last} -> out_data=44, out_count=1, out_err=1; next frame {5 last} -> out_data=5, out_err=0.
REQ-036 Frame {1000 last} with out_ready=0 for 5 cycles -> out_valid and out_data=1000 held stable, in_ready=0 throughout; out_ready=1 -> IDLE next cycle.
REQ-037 Frame {3000, 3000} then rst_n low for 2 cycles, then frame {7 last} -> out_data=7, out_count=1.
REQ-038 Random frames of 1-1100 random 12-bit terms with random in_valid/out_ready gaps -> out_data equals golden sum mod 4051, out_count = min(n, 1023), no term lost or duplicated.

Source files
------------

// File: rtl/mod4051_accumulator.sv
// ---------------------------------------------------------------------------
// mod4051_accumulator
//
// Adds up a frame of residue terms modulo MOD and hands the reduced sum to
// downstream through a valid/ready pair. Each term comes from an upstream
// residue LUT stage. Because 2^W < 2*MOD, a single conditional subtraction
// is enough to bring any W-bit term, or any sum of two reduced values,
// back below MOD.
//
// Ports
//   clk        : single clock, all state updates on the rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : upstream term present
//   in_ready   : block accepts a term this cycle (low while a result is held)
//   in_data    : W-bit partial residue
//   in_last    : term closes the current frame
//   out_valid  : frame result available
//   out_ready  : downstream accepts the result
//   out_data   : frame sum modulo MOD, always < MOD
//   out_count  : number of accepted terms, saturating at 2^CW-1
//   out_err    : at least one term in the frame was >= MOD
// ---------------------------------------------------------------------------
module mod4051_accumulator #(
  parameter int MOD = 4051,
  parameter int W   = 12,
  parameter int CW  = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic [CW-1:0] out_count,
  output logic          out_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [W:0]    MOD_X   = (W+1)'(MOD);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  // One conditional subtraction of MOD; valid for any input below 2*MOD.
  function automatic logic [W-1:0] reduce_once(input logic [W:0] x);
    logic [W-1:0] r;
    if (x >= MOD_X) begin
      r = W'(x - MOD_X);
    end else begin
      r = x[W-1:0];
    end
    return r;
  endfunction

  state_t        state_q,     state_d;
  logic [W-1:0]  acc_q,       acc_d;
  logic [CW-1:0] cnt_q,       cnt_d;
  logic          err_q,       err_d;
  logic          in_ready_q,  in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_data_q,  out_data_d;
  logic [CW-1:0] out_count_q, out_count_d;
  logic          out_err_q,   out_err_d;

  logic [W-1:0]  term_s;
  logic [W:0]    sum_s;
  logic [W-1:0]  acc_next_s;
  logic [CW-1:0] cnt_inc_s;
  logic          bad_s;
  logic          accept_s;

  // Datapath: reduce the incoming term, add it, reduce the sum, bump count.
  always_comb begin
    term_s     = reduce_once({1'b0, in_data});
    sum_s      = {1'b0, acc_q} + {1'b0, term_s};
    acc_next_s = reduce_once(sum_s);
    bad_s      = ({1'b0, in_data} >= MOD_X);
    accept_s   = in_valid && in_ready_q;
    if (cnt_q == CNT_MAX) begin
      cnt_inc_s = cnt_q;
    end else begin
      cnt_inc_s = cnt_q + CNT_ONE;
    end
  end

  // Next-state and next-output logic for the IDLE/ACC/HOLD controller.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_err_d   = out_err_q;

    case (state_q)
      IDLE, ACC: begin
        if (accept_s) begin
          if (in_last) begin
            // Close the frame: present the result, running totals restart.
            state_d     = HOLD;
            out_valid_d = 1'b1;
            out_data_d  = acc_next_s;
            out_count_d = cnt_inc_s;
            out_err_d   = err_q | bad_s;
            acc_d       = '0;
            cnt_d       = '0;
            err_d       = 1'b0;
          end else begin
            state_d = ACC;
            acc_d   = acc_next_s;
            cnt_d   = cnt_inc_s;
            err_d   = err_q | bad_s;
          end
        end else begin
          state_d = state_q;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          acc_d       = '0;
          cnt_d       = '0;
          err_d       = 1'b0;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        acc_d       = '0;
        cnt_d       = '0;
        err_d       = 1'b0;
      end
    endcase

    // in_ready is registered so it depends only on state, never on in_valid.
    in_ready_d = (state_d != HOLD);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_err_q   <= out_err_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_mod4051_accumulator.sv
// Testbench for mod4051_accumulator: queue scoreboard with a separate monitor.
module tb_mod4051_accumulator;

  localparam int MOD   = 4051;
  localparam int W     = 12;
  localparam int CW    = 10;
  localparam int BOUND = 4000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic [CW-1:0] out_count;
  logic          out_err;

  typedef struct {
    int unsigned data;
    int unsigned count;
    bit          err;
  } exp_t;

  exp_t        sb[$];
  int unsigned terms[$];
  int          checks = 0;
  int          errors = 0;
  int          rdy_mode = 0;   // 0: always ready, 1: random, 2: never ready

  mod4051_accumulator #(.MOD(MOD), .W(W), .CW(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Golden result of a frame: plain sum of raw terms modulo MOD.
  task automatic push_expected();
    exp_t   e;
    longint sum;
    bit     bad;
    sum = 0;
    bad = 1'b0;
    foreach (terms[i]) begin
      sum += longint'(terms[i]);
      if (terms[i] >= MOD) bad = 1'b1;
    end
    e.data  = int'(sum % MOD);
    e.count = (terms.size() > 1023) ? 1023 : terms.size();
    e.err   = bad;
    sb.push_back(e);
  endtask

  // Drive the terms queue as one frame, with random idle gaps between beats.
  task automatic send_frame(input bit with_last, input int gapmax);
    int n;
    int g;
    int w;
    n = terms.size();
    for (int i = 0; i < n; i++) begin
      g = $urandom_range(gapmax, 0);
      repeat (g) begin
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = W'($urandom);
        in_last  = 1'($urandom);
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = W'(terms[i]);
      in_last  = with_last && (i == n - 1);
      w = 0;
      while (!in_ready && w < BOUND) begin
        @(negedge clk);
        w++;
      end
      if (!in_ready) begin
        chk("in_ready_timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
      if (in_last) push_expected();
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (with_last) chk("latency_out_valid", longint'(out_valid), 1);
  endtask

  task automatic chk_reset_values();
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_out_data",  longint'(out_data), 0);
    chk("rst_out_count", longint'(out_count), 0);
    chk("rst_out_err",   longint'(out_err), 0);
    chk("rst_in_ready",  longint'(in_ready), 1);
  endtask

  // Monitor: drives out_ready, pops and compares on every hand-off.
  initial begin : monitor
    bit          waiting;
    bit          bubble;
    bit          r;
    exp_t        e;
    int unsigned h_data;
    int unsigned h_count;
    bit          h_err;
    waiting = 1'b0;
    bubble  = 1'b0;
    h_data  = 0;
    h_count = 0;
    h_err   = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        waiting   = 1'b0;
        bubble    = 1'b0;
        out_ready = 1'b0;
      end else begin
        if (bubble) begin
          chk("bubble_out_valid", longint'(out_valid), 0);
          chk("bubble_in_ready", longint'(in_ready), 1);
          bubble = 1'b0;
        end
        case (rdy_mode)
          0:       r = 1'b1;
          1:       r = 1'($urandom);
          default: r = 1'b0;
        endcase
        out_ready = r;
        if (out_valid) begin
          chk("hold_in_ready", longint'(in_ready), 0);
          if (waiting) begin
            chk("stable_data",  longint'(out_data), longint'(h_data));
            chk("stable_count", longint'(out_count), longint'(h_count));
            chk("stable_err",   longint'(out_err), longint'(h_err));
          end
          if (r) begin
            if (sb.size() == 0) begin
              chk("unexpected_result", 1, 0);
            end else begin
              e = sb.pop_front();
              chk("out_data",  longint'(out_data), longint'(e.data));
              chk("out_count", longint'(out_count), longint'(e.count));
              chk("out_err",   longint'(out_err), longint'(e.err));
            end
            waiting = 1'b0;
            bubble  = 1'b1;
          end else begin
            waiting = 1'b1;
            h_data  = out_data;
            h_count = out_count;
            h_err   = out_err;
          end
        end else begin
          waiting = 1'b0;
        end
      end
    end
  end

  // Stimulus: directed frames, reset cases, then random frames.
  initial begin : driver
    int n;
    int w;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_values();
    rst_n = 1'b1;

    // {4050, 1 last}
    rdy_mode = 0;
    terms = '{4050, 1};
    send_frame(1'b1, 0);
    // {2000, 2000, 100 last}
    terms = '{2000, 2000, 100};
    send_frame(1'b1, 0);
    // {4095 last} then {5 last}
    terms = '{4095};
    send_frame(1'b1, 0);
    terms = '{5};
    send_frame(1'b1, 0);

    // Back-pressure: result held for 5 cycles.
    rdy_mode = 2;
    terms = '{1000};
    send_frame(1'b1, 0);
    repeat (5) begin
      @(negedge clk);
      chk("bp_out_valid", longint'(out_valid), 1);
      chk("bp_out_data",  longint'(out_data), 1000);
      chk("bp_in_ready",  longint'(in_ready), 0);
    end
    rdy_mode = 0;
    w = 0;
    while (out_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("bp_released", longint'(out_valid), 0);

    // Reset mid-frame after {3000, 3000}.
    terms = '{3000, 3000};
    send_frame(1'b0, 0);
    rst_n = 1'b0;
    #1;
    chk_reset_values();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    terms = '{7};
    send_frame(1'b1, 0);

    // Reset while a result is held: the result is discarded.
    rdy_mode = 2;
    terms = '{9};
    send_frame(1'b1, 0);
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk_reset_values();
    @(negedge clk);
    rst_n = 1'b1;
    rdy_mode = 0;
    terms = '{4051, 4050, 4050};
    send_frame(1'b1, 1);

    // Random frames, including one long frame to hit count saturation.
    rdy_mode = 1;
    for (int f = 0; f < 7; f++) begin
      n = (f == 0) ? 1100 : $urandom_range(1100, 1);
      terms.delete();
      for (int i = 0; i < n; i++) terms.push_back($urandom_range(4095, 0));
      send_frame(1'b1, (f == 0) ? 0 : 2);
    end

    rdy_mode = 0;
    w = 0;
    while (sb.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", longint'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
